// File: rtl/dmem_bridge.sv
// dmem_bridge: mem-stage to req/addr_ok/data_ok data bus bridge with pipeline stall.
// Optional watchdog enabled by defining DMEM_WDOG_EN.
module dmem_bridge #(
   parameter int          TIMEOUT  = 64,
   parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        memen,
   input  logic [3:0]  sel,
   input  logic [1:0]  size,
   input  logic [31:0] addrM,
   input  logic [31:0] wdataM,
   input  logic        hold,
   output logic        stallM,
   output logic [31:0] rdataM,
   output logic        err,
   output logic        data_req,
   output logic        data_wr,
   output logic [1:0]  data_size,
   output logic [31:0] data_addr,
   output logic [3:0]  data_wstrb,
   output logic [31:0] data_wdata,
   input  logic        data_addr_ok,
   input  logic        data_data_ok,
   input  logic [31:0] data_rdata
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic [3:0]  sel_q, sel_d;
   logic [1:0]  size_q, size_d;
   logic        err_q, err_d, expire;
   logic        busy;
   assign busy = (state_q == REQ) || (state_q == WAIT);
`ifdef DMEM_WDOG_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   assign cnt_d  = busy ? cnt_q + 1'b1 : '0;
   assign expire = busy && (cnt_q == CW'(TIMEOUT - 1)) && !(state_q == WAIT && data_data_ok);
   always_ff @(posedge clk or negedge rst)
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
`else
   assign expire = 1'b0;
`endif
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      sel_d      = sel_q;
      size_d     = size_q;
      rdata_d    = rdata_q;
      err_d      = 1'b0;
      data_req   = 1'b0;
      data_addr  = addr_q;
      data_wdata = wdata_q;
      data_wstrb = sel_q;
      data_size  = size_q;
      case (state_q)
         IDLE: begin
            data_req   = memen;
            data_addr  = addrM;
            data_wdata = wdataM;
            data_wstrb = sel;
            data_size  = size;
            if (memen) begin
               addr_d  = addrM;
               wdata_d = wdataM;
               sel_d   = sel;
               size_d  = size;
               state_d = data_addr_ok ? WAIT : REQ;
            end
         end
         REQ: begin
            data_req = !expire;
            if (data_addr_ok && !expire) state_d = WAIT;
         end
         WAIT: if (data_data_ok) begin
            rdata_d = (sel_q == 4'd0) ? data_rdata : rdata_q;
            state_d = DONE;
         end
         DONE: state_d = hold ? DONE : IDLE;
         default: state_d = IDLE;
      endcase
      // Watchdog expiry abandons the access and completes it with error data
      if (expire) begin
         state_d = DONE;
         rdata_d = ERR_DATA;
         err_d   = 1'b1;
      end
   end
   assign data_wr = data_req && (data_wstrb != 4'd0);
   assign stallM  = ((state_q == IDLE) && memen) || busy;
   assign rdataM  = rdata_q;
   assign err     = err_q;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         sel_q   <= '0;
         size_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         sel_q   <= sel_d;
         size_q  <= size_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Mem-stage data-memory bridge for the five-stage MIPS pipeline. It converts the single-cycle mem-stage access (enable, byte selects, address, store data) into a split address/data handshake bus (req/addr_ok/data_ok) toward data SRAM or cache. It stalls the pipeline until the access completes and then returns the raw 32-bit load word for the existing byte/half extraction logic.

## Interface
- TIMEOUT, 64: watchdog limit in cycles; used only with DMEM_WDOG_EN.
- ERR_DATA, 32'hDEADBEEF: load data returned on watchdog expiry.

Ports:
- clk  input  1  pipeline clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-low reset
- memen  input  1  mem-stage instruction performs a load or store
- sel  input  4  byte write strobes; nonzero means store, 0 means load
- size  input  2  access size: 0 byte, 1 half, 2 word
- addrM  input  32  byte address from mem-stage ALU result
- wdataM  input  32  lane-aligned store data
- hold  input  1  pipeline held by another source (divider, hazard unit)
- stallM  output  1  freeze F/D/E/M and bubble W while the access is in flight
- rdataM  output  32  raw load word; valid in DONE
- err  output  1  one-cycle pulse on watchdog expiry (tied 0 without DMEM_WDOG_EN)
- data_req  output  1  bus request
- data_wr  output  1  1 = write
- data_size  output  2  copy of size
- data_addr  output  32  request address
- data_wstrb  output  4  copy of sel (0 for loads)
- data_wdata  output  32  store data
- data_addr_ok  input  1  request accepted this cycle
- data_data_ok  input  1  read data valid or write complete this cycle
- data_rdata  input  32  read data

## Operation
- State machine: IDLE, REQ, WAIT, DONE.
- IDLE:
  - With memen=1, drive data_req=1 combinationally from the mem-stage inputs.
  - Latch addr, wdata, sel and size into holding registers.
  - Next state is WAIT if data_addr_ok, else REQ.
- REQ:
  - data_req=1, with bus fields driven from the holding registers. They stay stable until addr_ok.
  - On data_addr_ok, go to WAIT.
- WAIT:
  - data_req=0.
  - On data_data_ok, register data_rdata into rdataM for loads; for stores, rdataM keeps its prior value. Go to DONE.
- DONE:
  - stallM=0, so the instruction leaves M at the end of this cycle.
  - If hold=1, stay in DONE: rdataM is held and no reissue occurs. Otherwise go to IDLE.
- stallM = (IDLE & memen) | REQ | WAIT.
- data_wr = |sel.
- data_data_ok outside WAIT is ignored. This covers a stale response after reset and a same-cycle addr_ok+data_ok in IDLE/REQ. The bus must not return data_ok in the addr_ok cycle.
- data_addr_ok outside IDLE/REQ is ignored.
- Misaligned addresses are forwarded unchanged; alignment exceptions are handled elsewhere.

## Timing
- Reset values: state IDLE; rdataM=0; err=0; holding registers 0. data_req, data_wr and stallM are 0 while memen=0.
- Zero-wait bus (addr_ok with req, data_ok next cycle):
  - Cycle 0: IDLE, req issued.
  - Cycle 1: WAIT, data_ok arrives.
  - Cycle 2: DONE, stall released.
  - Total: 2 stall cycles per access; rdataM valid from cycle 2.
- Each addr_ok wait cycle and each data_ok wait cycle adds exactly one stall cycle.
- Back-to-back accesses: the DONE to IDLE transition means a following memory instruction issues its request on the cycle after DONE.
- Reset asserted mid-operation: the bridge returns to IDLE immediately and the outstanding transaction is abandoned.

## Configuration
- DMEM_WDOG_EN defined:
  - A counter runs in REQ and WAIT and clears on entry to IDLE.
  - When it reaches TIMEOUT, the bridge drops data_req, forces rdataM=ERR_DATA, pulses err for one cycle and enters DONE.
- DMEM_WDOG_EN undefined: no counter, err tied to 0, and the bridge waits indefinitely.

## Test plan
- Load, addr=0x100, zero-wait bus returning 0x12345678:
  - stallM high for 2 cycles; rdataM=0x12345678 in DONE.
  - data_wr=0, data_wstrb=0.
- Store, sel=4'b0011, wdata=0x0000ABCD, addr_ok delayed 3 cycles:
  - data_req held 4 cycles with stable addr, wdata and wstrb.
  - stallM high 5 cycles; exactly one write accepted.
- Load completes while hold=1 for 2 cycles:
  - Bridge stays in DONE 3 cycles with rdataM stable and no second data_req.
- Reset asserted in WAIT, then data_ok pulse after release:
  - Bridge in IDLE, rdataM=0, stray data_ok ignored, stallM=0.
- Two consecutive loads (0x200, 0x204):
  - Two separate requests, each with 2 stall cycles; second req issued the cycle after the first DONE.
- With DMEM_WDOG_EN and TIMEOUT=8, load with no data_ok:
  - After 8 wait cycles: err pulses once, rdataM=0xDEADBEEF, stall releases.
